// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - APB requester state encoding shared with APB_slave verification.
package apb_pkg;

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = APB_IDLE,
    SETUP  = APB_SETUP,
    ACCESS = APB_ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating wait-state counter; expired flags the cycle that reaches limit.
module apb_wait_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W:0]   bumped;

  assign bumped = {1'b0, count} + (W+1)'(1);

  // Combinational so the abort lands on the same edge as the limit-th idle cycle.
  assign expired = enable && (bumped >= {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != limit)) begin
      count <= bumped[W-1:0];
    end
  end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester; optional abort under APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int A_WIDTH        = 8,
  parameter int D_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               p_clk,
  input  logic               p_rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [D_WIDTH-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               p_sel,
  output logic               p_enable,
  output logic               p_write,
  output logic [A_WIDTH-1:0] p_addr,
  output logic [D_WIDTH-1:0] wr_data,
  input  logic [D_WIDTH-1:0] rd_data,
  input  logic               p_ready,
  input  logic               p_slverr
);

  apb_state_e state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic expired;

  apb_wait_timer #(
    .W(CW)
  ) u_wait_timer (
    .clk     (p_clk),
    .rst_n   (p_rstn),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !p_ready),
    .limit   (CW'(TIMEOUT_CYCLES)),
    .expired (expired)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  // Ready also in the completing ACCESS cycle so back-to-back transfers skip IDLE.
  assign cmd_ready = p_rstn && ((state == IDLE) || ((state == ACCESS) && p_ready));

  always_ff @(posedge p_clk or negedge p_rstn) begin
    if (!p_rstn) begin
      state     <= IDLE;
      p_sel     <= 1'b0;
      p_enable  <= 1'b0;
      p_write   <= 1'b0;
      p_addr    <= '0;
      wr_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            p_write <= cmd_write;
            p_addr  <= cmd_addr;
            wr_data <= cmd_wdata;
            p_sel   <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          p_enable <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (p_ready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= p_slverr;
            rsp_rdata <= (!p_write && !p_slverr) ? rd_data : '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            if (cmd_valid) begin
              p_write  <= cmd_write;
              p_addr   <= cmd_addr;
              wr_data  <= cmd_wdata;
              p_enable <= 1'b0;
              state    <= SETUP;
            end else begin
              p_sel    <= 1'b0;
              p_enable <= 1'b0;
              state    <= IDLE;
            end
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (expired) begin
            p_sel       <= 1'b0;
            p_enable    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= IDLE;
          end
`endif
        end
        default: begin
          p_sel    <= 1'b0;
          p_enable <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed and randomized bench for apb_master with a memory-backed responder model.
module tb_apb_master;

  logic       p_clk = 1'b0;
  logic       p_rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       p_sel;
  logic       p_enable;
  logic       p_write;
  logic [7:0] p_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  logic       p_ready = 1'b0;
  logic       p_slverr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc, lat, t1, t2;
  logic [7:0] bus_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_b;

  apb_master dut (
    .p_clk       (p_clk),
    .p_rstn      (p_rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .p_sel       (p_sel),
    .p_enable    (p_enable),
    .p_write     (p_write),
    .p_addr      (p_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .p_ready     (p_ready),
    .p_slverr    (p_slverr)
  );

  always #5 p_clk = ~p_clk;
  always @(posedge p_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; the responder answers after `waits` ACCESS cycles.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input int waits, input bit serr, input string tag);
    logic [7:0] exp_rdata;
    int n, a;
    bit done;
    exp_rdata = (wr || serr) ? 8'h00 : ref_mem[addr];
    if (wr && !serr) ref_mem[addr] = wdata;
    @(negedge p_clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    @(negedge p_clk);
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom;
    chk({tag, ".setup_sel_en"}, {p_sel, p_enable}, 2'b10);
    chk({tag, ".setup_addr"}, p_addr, addr);
    chk({tag, ".setup_write"}, p_write, wr);
    n = 1; a = 0; done = 0;
    while (!done && n < 64) begin
      if (p_sel && p_enable) begin
        chk({tag, ".access_addr"}, p_addr, addr);
        if (wr) chk({tag, ".access_wdata"}, wr_data, wdata);
        p_ready  = (a == waits);
        p_slverr = p_ready ? serr : 1'($urandom);
        rd_data  = p_ready ? bus_mem[p_addr] : 8'($urandom);
        if (p_ready && p_write && !serr) bus_mem[p_addr] = wr_data;
        a++;
      end
      @(negedge p_clk);
      n++;
      if (rsp_valid) done = 1;
    end
    p_ready = 1'b0; p_slverr = 1'b0;
    chk({tag, ".rsp_seen"}, done, 1);
    chk({tag, ".latency"}, n, waits + 3);
    chk({tag, ".rsp_err"}, rsp_err, serr);
    chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, ".rsp_timeout"}, rsp_timeout, 0);
    chk({tag, ".idle_sel_en"}, {p_sel, p_enable}, 2'b00);
    chk({tag, ".idle_ready"}, cmd_ready, 1);
    @(negedge p_clk);
    chk({tag, ".rsp_pulse"}, rsp_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[3] = 8'h5A; ref_mem[3] = 8'h5A;

    #12;
    chk("reset.cmd_ready", cmd_ready, 0);
    chk("reset.outputs", {p_sel, p_enable, p_write, p_addr, wr_data, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("reset.rdata", rsp_rdata, 0);
    @(negedge p_clk);
    p_rstn = 1'b1;
    #1;
    chk("post_reset.cmd_ready", cmd_ready, 1);

    xfer(1'b0, 8'h03, 8'h00, 2, 1'b0, "read_5a_2ws");
    xfer(1'b1, 8'h03, 8'hA5, 0, 1'b0, "write_a5_0ws");
    xfer(1'b0, 8'h03, 8'h00, 1, 1'b0, "readback_a5");
    xfer(1'b0, 8'h03, 8'h00, 0, 1'b1, "read_slverr");
    xfer(1'b1, 8'h04, 8'h3C, 1, 1'b1, "write_slverr");

    // Back-to-back: command B is already valid when A completes.
    exp_b = ref_mem[8'h20];
    ref_mem[8'h10] = 8'h11;
    @(negedge p_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h11;
    @(negedge p_clk);
    cmd_write = 1'b0; cmd_addr = 8'h20; cmd_wdata = 8'hEE;
    chk("b2b.setup_a", {p_sel, p_enable}, 2'b10);
    @(negedge p_clk);
    chk("b2b.access_a", {p_sel, p_enable}, 2'b11);
    p_ready = 1'b1; p_slverr = 1'b0; rd_data = 8'h00;
    bus_mem[p_addr] = wr_data;
    #1;
    chk("b2b.ready_in_access", cmd_ready, 1);
    @(negedge p_clk);
    t1 = cyc;
    cmd_valid = 1'b0;
    chk("b2b.rsp_a", {rsp_valid, rsp_err}, 2'b10);
    chk("b2b.setup_b", {p_sel, p_enable}, 2'b10);
    chk("b2b.addr_b", p_addr, 8'h20);
    rd_data = bus_mem[8'h20];
    @(negedge p_clk);
    chk("b2b.access_b", {p_sel, p_enable, rsp_valid}, 3'b110);
    @(negedge p_clk);
    t2 = cyc;
    p_ready = 1'b0;
    chk("b2b.rsp_b", {rsp_valid, rsp_err}, 2'b10);
    chk("b2b.rdata_b", rsp_rdata, exp_b);
    chk("b2b.spacing", t2 - t1, 2);
    chk("b2b.mem_a", bus_mem[8'h10], 8'h11);

    for (int k = 0; k < 20; k++) begin
      xfer(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
           int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0), "random");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    @(negedge p_clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h07;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    acc = 0; lat = 0;
    while (!rsp_valid && lat < 64) begin
      if (p_sel && p_enable) acc++;
      @(negedge p_clk);
      lat++;
    end
    chk("timeout.access_cycles", acc, 16);
    chk("timeout.rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b111);
    chk("timeout.rdata", rsp_rdata, 0);
    chk("timeout.idle", {p_sel, p_enable, cmd_ready}, 3'b001);
    @(negedge p_clk);
    xfer(1'b0, 8'h07, 8'h00, 15, 1'b0, "limit_ready_wins");
`endif

    // Reset while a transfer sits in ACCESS.
    @(negedge p_clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    @(negedge p_clk);
    chk("midreset.in_access", {p_sel, p_enable}, 2'b11);
    #2 p_rstn = 1'b0;
    #1;
    chk("midreset.async_clear", {p_sel, p_enable, rsp_valid}, 3'b000);
    chk("midreset.cmd_ready", cmd_ready, 0);
    @(negedge p_clk);
    p_rstn = 1'b1;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge p_clk);
      if (rsp_valid || p_sel) acc++;
    end
    chk("midreset.no_rsp", acc, 0);
    xfer(1'b1, 8'h31, 8'hC3, 1, 1'b0, "post_reset_write");
    xfer(1'b0, 8'h31, 8'h00, 0, 1'b0, "post_reset_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester driving the `APB_slave` peripheral bus. It accepts one read or write command at a time on a valid/ready interface and runs the APB SETUP→ACCESS sequence, including any wait states. It returns read data and error status as a one-cycle response pulse. It sits between the bus-fabric/CPU side and one or more APB responders.

## Interface
- `A_WIDTH`, 8, address width
- `D_WIDTH`, 8, data width
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles with `p_ready` low before abort (used only with the timeout feature)
- `p_clk`  in  1  clock; all logic on the rising edge
- `p_rstn`  in  1  reset; asynchronous assert, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  A_WIDTH  target address
- `cmd_wdata`  in  D_WIDTH  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  D_WIDTH  read data; 0 for writes and errors
- `rsp_err`  out  1  `p_slverr` sampled at completion, or timeout
- `rsp_timeout`  out  1  completion was a timeout abort (tied 0 when the feature is compiled out)
- `p_sel`, `p_enable`, `p_write`  out  1  APB control
- `p_addr`  out  A_WIDTH  APB address
- `wr_data`  out  D_WIDTH  APB write data
- `rd_data`  in  D_WIDTH  APB read data
- `p_ready`, `p_slverr`  in  1  APB responder status

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE**
  - `p_sel=0`, `p_enable=0`, `cmd_ready=1`.
  - On `cmd_valid`: latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `p_write`/`p_addr`/`wr_data`, then go to SETUP.
- **SETUP** (exactly one cycle)
  - `p_sel=1`, `p_enable=0`, `cmd_ready=0`.
  - Next state is always ACCESS.
- **ACCESS**
  - `p_sel=1`, `p_enable=1`.
  - `p_addr`, `p_write` and `wr_data` are held stable until the transfer completes.
  - Completion occurs when `p_ready=1` is sampled. At completion:
    - `rsp_err <= p_slverr`.
    - `rsp_rdata <= (!p_write && !p_slverr) ? rd_data : 0`.
    - `rsp_valid <= 1` for one cycle.
- **Back-to-back commands**
  - `cmd_ready=1` in ACCESS while `p_ready=1`.
  - If `cmd_valid` is also high, the new command is latched and the next state is SETUP: `p_sel` stays 1 and `p_enable` drops to 0.
  - Otherwise the next state is IDLE.
- `cmd_ready` is combinational from state and `p_ready`. It is 0 while `p_rstn=0`.
- The block does not apply backpressure on responses; the consumer must always accept `rsp_valid`.
- **Reset**
  - Reset is asynchronous to IDLE.
  - All outputs go to 0 except `cmd_ready`, which is 1 in IDLE after reset releases.
  - A transfer in flight is dropped without a response.

## Timing
- Command handshake at edge N:
  - SETUP is visible in cycle N+1.
  - ACCESS begins in cycle N+2.
- With zero wait states, `p_ready` is sampled at edge N+3 and `rsp_valid` is high in cycle N+3.
- Each wait state adds one cycle.
- Back-to-back sustained rate: one transfer per 2 cycles.
- All APB outputs and `rsp_*` outputs are registered.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- **Defined:**
  - The wait counter increments on each ACCESS cycle with `p_ready=0` and clears on entry to SETUP.
  - When the count reaches `TIMEOUT_CYCLES`, the transfer aborts and the next state is IDLE.
  - On abort: `p_sel=0`, `p_enable=0`, `rsp_valid=1`, `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
  - A `p_ready=1` arriving in the same cycle as the limit wins, and completion is normal.
- **Undefined:**
  - The block waits indefinitely and `rsp_timeout` is tied 0.
  - No counter logic is present.

## Structure
- Package `apb_pkg`:
  - `apb_state_e` (IDLE, SETUP, ACCESS).
  - Constants `APB_IDLE`/`APB_SETUP`/`APB_ACCESS`, shared with `APB_slave` verification.
- Sub-module `apb_wait_timer`:
  - Saturating counter with inputs clear, enable and limit; output `expired`.
  - Instantiated only under `APB_MASTER_TIMEOUT_EN`.

## Test plan
- Write 0xA5 to address 0x03, `p_ready` high in the first ACCESS cycle:
  - `p_sel`/`p_enable` sequence is 10→11.
  - `wr_data` is 0xA5.
  - `rsp_valid` pulses 3 cycles after the handshake with `rsp_err=0`.
- Read address 0x03 with 2 wait states and `rd_data=0x5A`:
  - ACCESS lasts 3 cycles.
  - `rsp_rdata=0x5A`, `rsp_valid` at cycle N+5.
- Read with `p_slverr=1` at completion: `rsp_err=1`, `rsp_rdata=0`.
- Two commands held valid back-to-back: second SETUP follows the first ACCESS directly with `p_sel` held at 1; two `rsp_valid` pulses, 2 cycles apart.
- Timeout build, `p_ready` held 0:
  - Abort after 16 ACCESS cycles with `rsp_err=1`, `rsp_timeout=1`.
  - Block returns to IDLE with `cmd_ready=1`.
- Assert `p_rstn=0` mid-ACCESS:
  - `p_sel`/`p_enable` go to 0 asynchronously, with no `rsp_valid`.
  - After release, a new write completes normally.
